// File: rtl/iq_wakeup_sched.sv
// rtl/iq_wakeup_sched.sv - issue-queue wake-up: per-channel tag delay lines and entry source-ready tracking
module iq_wakeup_sched #(
  parameter int ISSUE_NUM = 4,
  parameter int PRF_WIDTH = 6,
  parameter int CIQ_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter int MAX_LAT   = 4,
  parameter int LAT_W     = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ISSUE_NUM-1:0]           grant_vld,
  input  logic [ISSUE_NUM*PRF_WIDTH-1:0] grant_prd,
  input  logic [ISSUE_NUM*LAT_W-1:0]     grant_lat,
  input  logic                           alloc_en,
  input  logic [IDX_W-1:0]               alloc_idx,
  input  logic [PRF_WIDTH-1:0]           alloc_prs1,
  input  logic [PRF_WIDTH-1:0]           alloc_prs2,
  input  logic                           alloc_rdy1,
  input  logic                           alloc_rdy2,
  input  logic [CIQ_DEPTH-1:0]           dealloc,
  input  logic                           flush,
  output logic [ISSUE_NUM-1:0]           tag_bus_vld,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0] tag_bus,
  output logic [CIQ_DEPTH-1:0]           prs1_rdy,
  output logic [CIQ_DEPTH-1:0]           prs2_rdy,
  output logic [CIQ_DEPTH-1:0]           entry_rdy,
  output logic [ISSUE_NUM-1:0]           lat_conflict,
  output logic [ISSUE_NUM-1:0]           lat_err
);

  // Delay-line stages; an empty stage always carries tag 0 so the bus reads 0 when idle.
  logic [ISSUE_NUM-1:0][MAX_LAT-1:0]                stg_vld_q, stg_vld_d;
  logic [ISSUE_NUM-1:0][MAX_LAT-1:0][PRF_WIDTH-1:0] stg_tag_q, stg_tag_d;
  logic [ISSUE_NUM-1:0]                             conflict_q, conflict_d;
  logic [ISSUE_NUM-1:0]                             err_q, err_d;

  // Issue-queue entry state.
  logic [CIQ_DEPTH-1:0]                valid_q, valid_d;
  logic [CIQ_DEPTH-1:0]                r1_q, r1_d;
  logic [CIQ_DEPTH-1:0]                r2_q, r2_d;
  logic [CIQ_DEPTH-1:0][PRF_WIDTH-1:0] tag1_q, tag1_d;
  logic [CIQ_DEPTH-1:0][PRF_WIDTH-1:0] tag2_q, tag2_d;

  logic [ISSUE_NUM-1:0]           bus_vld;
  logic [ISSUE_NUM*PRF_WIDTH-1:0] bus_tag;

  // True when any live broadcast channel carries tag t this cycle.
  function automatic logic bus_hit(input logic [PRF_WIDTH-1:0]           t,
                                   input logic [ISSUE_NUM-1:0]           bv,
                                   input logic [ISSUE_NUM*PRF_WIDTH-1:0] bt);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < ISSUE_NUM; c++) begin
      if (bv[c] && (bt[c*PRF_WIDTH +: PRF_WIDTH] == t)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Stage 0 of every channel is the broadcast bus.
  always_comb begin
    bus_vld = '0;
    bus_tag = '0;
    for (int c = 0; c < ISSUE_NUM; c++) begin
      bus_vld[c]                          = stg_vld_q[c][0];
      bus_tag[c*PRF_WIDTH +: PRF_WIDTH]   = stg_tag_q[c][0];
    end
  end

  // Shift the delay lines and slot new grants in, keeping the older tag on a collision.
  always_comb begin
    int lat;
    stg_vld_d  = '0;
    stg_tag_d  = '0;
    conflict_d = '0;
    err_d      = '0;
    lat        = 0;
    for (int c = 0; c < ISSUE_NUM; c++) begin
      for (int k = 0; k < MAX_LAT - 1; k++) begin
        stg_vld_d[c][k] = stg_vld_q[c][k+1];
        stg_tag_d[c][k] = stg_tag_q[c][k+1];
      end
      lat = int'(grant_lat[c*LAT_W +: LAT_W]);
      if (grant_vld[c]) begin
        if (lat == 0 || lat > MAX_LAT) begin
          err_d[c] = 1'b1;
        end else begin
          for (int k = 0; k < MAX_LAT; k++) begin
            if (k == lat - 1) begin
              if (stg_vld_d[c][k]) begin
                conflict_d[c] = 1'b1;
              end else begin
                stg_vld_d[c][k] = 1'b1;
                stg_tag_d[c][k] = grant_prd[c*PRF_WIDTH +: PRF_WIDTH];
              end
            end
          end
        end
      end
    end
    if (flush) begin
      stg_vld_d  = '0;
      stg_tag_d  = '0;
      conflict_d = '0;
      err_d      = '0;
    end
  end

  // Entry update: allocation (with same-cycle bypass) beats dealloc, dealloc beats wake-up.
  always_comb begin
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      if (alloc_en && (alloc_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
        tag1_d[i]  = alloc_prs1;
        tag2_d[i]  = alloc_prs2;
        r1_d[i]    = alloc_rdy1 | (alloc_prs1 == '0) | bus_hit(alloc_prs1, bus_vld, bus_tag);
        r2_d[i]    = alloc_rdy2 | (alloc_prs2 == '0) | bus_hit(alloc_prs2, bus_vld, bus_tag);
      end else if (dealloc[i]) begin
        valid_d[i] = 1'b0;
        r1_d[i]    = 1'b0;
        r2_d[i]    = 1'b0;
      end else if (valid_q[i]) begin
        r1_d[i] = r1_q[i] | bus_hit(tag1_q[i], bus_vld, bus_tag);
        r2_d[i] = r2_q[i] | bus_hit(tag2_q[i], bus_vld, bus_tag);
      end
    end
    if (flush) begin
      valid_d = '0;
      r1_d    = '0;
      r2_d    = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q  <= '0;
      stg_tag_q  <= '0;
      conflict_q <= '0;
      err_q      <= '0;
      valid_q    <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      stg_tag_q  <= stg_tag_d;
      conflict_q <= conflict_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
    end
  end

  assign tag_bus_vld  = bus_vld;
  assign tag_bus      = bus_tag;
  assign prs1_rdy     = r1_q;
  assign prs2_rdy     = r2_q;
  assign entry_rdy    = valid_q & r1_q & r2_q;
  assign lat_conflict = conflict_q;
  assign lat_err      = err_q;

endmodule

// File: tb/tb_iq_wakeup_sched.sv
// tb/tb_iq_wakeup_sched.sv - table, corner-case and randomized checks of iq_wakeup_sched against a schedule model
module tb_iq_wakeup_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  grant_vld;
  logic [23:0] grant_prd;
  logic [11:0] grant_lat;
  logic        alloc_en;
  logic [3:0]  alloc_idx;
  logic [5:0]  alloc_prs1, alloc_prs2;
  logic        alloc_rdy1, alloc_rdy2;
  logic [15:0] dealloc;
  logic        flush;
  logic [3:0]  tag_bus_vld;
  logic [23:0] tag_bus;
  logic [15:0] prs1_rdy, prs2_rdy, entry_rdy;
  logic [3:0]  lat_conflict, lat_err;

  iq_wakeup_sched dut (
    .clk(clk), .rst_n(rst_n),
    .grant_vld(grant_vld), .grant_prd(grant_prd), .grant_lat(grant_lat),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx),
    .alloc_prs1(alloc_prs1), .alloc_prs2(alloc_prs2),
    .alloc_rdy1(alloc_rdy1), .alloc_rdy2(alloc_rdy2),
    .dealloc(dealloc), .flush(flush),
    .tag_bus_vld(tag_bus_vld), .tag_bus(tag_bus),
    .prs1_rdy(prs1_rdy), .prs2_rdy(prs2_rdy), .entry_rdy(entry_rdy),
    .lat_conflict(lat_conflict), .lat_err(lat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gvld;
    logic [23:0] gprd;
    logic [11:0] glat;
    logic        aen;
    logic [3:0]  aidx;
    logic [5:0]  p1, p2;
    logic        r1, r2;
    logic [15:0] dealloc;
    logic        flush;
    logic [3:0]  e_vld;
    logic [23:0] e_tag;
    logic [15:0] e_p1, e_p2, e_er;
    logic [3:0]  e_conf, e_err;
  } vec_t;

  int n_vec;
  int n_err;
  int cyc;

  // Model: each channel is a calendar of broadcasts keyed by absolute cycle.
  bit         sch_v [4][8];
  logic [5:0] sch_t [4][8];
  bit         m_valid [16];
  bit         m_r1 [16];
  bit         m_r2 [16];
  logic [5:0] m_t1 [16];
  logic [5:0] m_t2 [16];
  logic [3:0] m_conf, m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 8; s++) begin
        sch_v[c][s] = 1'b0;
        sch_t[c][s] = '0;
      end
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
      m_t1[i] = '0; m_t2[i] = '0;
    end
    m_conf = '0;
    m_err  = '0;
  endtask

  function automatic bit on_bus(input logic [5:0] t, input logic [3:0] bv, input logic [23:0] bt);
    bit h;
    h = 1'b0;
    for (int c = 0; c < 4; c++)
      if (bv[c] && bt[c*6 +: 6] == t) h = 1'b1;
    return h;
  endfunction

  task automatic model_update(input vec_t v);
    int s;
    int lat;
    int d;
    logic [3:0]  bv;
    logic [23:0] bt;
    logic [3:0]  nconf, nerr;
    s = cyc % 8;
    bv = '0; bt = '0; nconf = '0; nerr = '0;
    for (int c = 0; c < 4; c++) begin
      bv[c] = sch_v[c][s];
      if (sch_v[c][s]) bt[c*6 +: 6] = sch_t[c][s];
    end
    if (v.flush) begin
      model_reset();
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (v.gvld[c]) begin
          lat = int'(v.glat[c*3 +: 3]);
          if (lat < 1 || lat > 4) nerr[c] = 1'b1;
          else begin
            d = (cyc + lat) % 8;
            if (sch_v[c][d]) nconf[c] = 1'b1;
            else begin
              sch_v[c][d] = 1'b1;
              sch_t[c][d] = v.gprd[c*6 +: 6];
            end
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (v.aen && int'(v.aidx) == i) begin
          m_valid[i] = 1'b1;
          m_t1[i] = v.p1;
          m_t2[i] = v.p2;
          m_r1[i] = v.r1 || v.p1 == 0 || on_bus(v.p1, bv, bt);
          m_r2[i] = v.r2 || v.p2 == 0 || on_bus(v.p2, bv, bt);
        end else if (v.dealloc[i]) begin
          m_valid[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
        end else if (m_valid[i]) begin
          if (on_bus(m_t1[i], bv, bt)) m_r1[i] = 1'b1;
          if (on_bus(m_t2[i], bv, bt)) m_r2[i] = 1'b1;
        end
      end
      m_conf = nconf;
      m_err  = nerr;
    end
    for (int c = 0; c < 4; c++) sch_v[c][s] = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    grant_vld = v.gvld; grant_prd = v.gprd; grant_lat = v.glat;
    alloc_en = v.aen; alloc_idx = v.aidx;
    alloc_prs1 = v.p1; alloc_prs2 = v.p2;
    alloc_rdy1 = v.r1; alloc_rdy2 = v.r2;
    dealloc = v.dealloc; flush = v.flush;
  endtask

  // One cycle: check outputs at the falling edge, apply inputs, advance at the rising edge.
  task automatic step(input vec_t v, input bit use_tbl, input int row);
    logic [3:0]  e_vld;
    logic [23:0] e_tag;
    logic [15:0] e_p1, e_p2, e_er;
    @(negedge clk);
    e_vld = '0; e_tag = '0; e_p1 = '0; e_p2 = '0; e_er = '0;
    for (int c = 0; c < 4; c++) begin
      e_vld[c] = sch_v[c][cyc % 8];
      if (e_vld[c]) e_tag[c*6 +: 6] = sch_t[c][cyc % 8];
    end
    for (int i = 0; i < 16; i++) begin
      e_p1[i] = m_r1[i];
      e_p2[i] = m_r2[i];
      e_er[i] = m_valid[i] & m_r1[i] & m_r2[i];
    end
    chk("tag_bus_vld", 64'(tag_bus_vld), 64'(e_vld));
    chk("tag_bus", 64'(tag_bus), 64'(e_tag));
    chk("prs1_rdy", 64'(prs1_rdy), 64'(e_p1));
    chk("prs2_rdy", 64'(prs2_rdy), 64'(e_p2));
    chk("entry_rdy", 64'(entry_rdy), 64'(e_er));
    chk("lat_conflict", 64'(lat_conflict), 64'(m_conf));
    chk("lat_err", 64'(lat_err), 64'(m_err));
    if (use_tbl) begin
      chk($sformatf("row%0d_tag_bus_vld", row), 64'(tag_bus_vld), 64'(v.e_vld));
      chk($sformatf("row%0d_tag_bus", row), 64'(tag_bus), 64'(v.e_tag));
      chk($sformatf("row%0d_prs1_rdy", row), 64'(prs1_rdy), 64'(v.e_p1));
      chk($sformatf("row%0d_prs2_rdy", row), 64'(prs2_rdy), 64'(v.e_p2));
      chk($sformatf("row%0d_entry_rdy", row), 64'(entry_rdy), 64'(v.e_er));
      chk($sformatf("row%0d_lat_conflict", row), 64'(lat_conflict), 64'(v.e_conf));
      chk($sformatf("row%0d_lat_err", row), 64'(lat_err), 64'(v.e_err));
    end
    drive(v);
    model_update(v);
    @(posedge clk);
    cyc++;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v = '{default: '0};
    v.gvld = 4'($urandom);
    for (int c = 0; c < 4; c++) begin
      v.gprd[c*6 +: 6] = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) v.glat[c*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
      else v.glat[c*3 +: 3] = 3'($urandom_range(1, 4));
    end
    v.aen  = 1'($urandom_range(0, 1));
    v.aidx = 4'($urandom);
    v.p1   = 6'($urandom_range(0, 15));
    v.p2   = 6'($urandom_range(0, 15));
    v.r1   = ($urandom_range(0, 3) == 0);
    v.r2   = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 2) == 0) v.dealloc = 16'(1 << $urandom_range(0, 15));
    if ($urandom_range(0, 5) == 0) v.dealloc = v.dealloc | 16'(1 << v.aidx);
    v.flush = ($urandom_range(0, 49) == 0);
    return v;
  endfunction

  vec_t tbl [19];
  vec_t zv;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    zv = '{default: '0};
    for (int i = 0; i < 19; i++) tbl[i] = '{default: '0};
    // Basic wake-up
    tbl[0].aen = 1; tbl[0].aidx = 3; tbl[0].p1 = 5; tbl[0].p2 = 7;
    tbl[1].gvld = 4'b0001; tbl[1].gprd = 24'd5; tbl[1].glat = 12'd2;
    tbl[3].gvld = 4'b0010; tbl[3].gprd = 24'd7 << 6; tbl[3].glat = 12'd1 << 3;
    tbl[3].e_vld = 4'b0001; tbl[3].e_tag = 24'd5;
    tbl[4].e_vld = 4'b0010; tbl[4].e_tag = 24'd7 << 6; tbl[4].e_p1 = 16'h0008;
    // Bypass
    tbl[5].gvld = 4'b0001; tbl[5].gprd = 24'd9; tbl[5].glat = 12'd1;
    tbl[5].e_p1 = 16'h0008; tbl[5].e_p2 = 16'h0008; tbl[5].e_er = 16'h0008;
    tbl[6].aen = 1; tbl[6].aidx = 0; tbl[6].p1 = 9; tbl[6].p2 = 0;
    tbl[6].e_vld = 4'b0001; tbl[6].e_tag = 24'd9;
    tbl[6].e_p1 = 16'h0008; tbl[6].e_p2 = 16'h0008; tbl[6].e_er = 16'h0008;
    // Collision on channel 2
    tbl[7].gvld = 4'b0100; tbl[7].gprd = 24'd11 << 12; tbl[7].glat = 12'd3 << 6;
    tbl[8].gvld = 4'b0100; tbl[8].gprd = 24'd12 << 12; tbl[8].glat = 12'd2 << 6;
    tbl[9].e_conf = 4'b0100;
    tbl[10].e_vld = 4'b0100; tbl[10].e_tag = 24'd11 << 12;
    for (int i = 7; i <= 12; i++) begin
      tbl[i].e_p1 = 16'h0009; tbl[i].e_p2 = 16'h0009; tbl[i].e_er = 16'h0009;
    end
    // Bad latency: ch3 lat=0, ch1 lat=5
    tbl[11].gvld = 4'b1010; tbl[11].gprd = (24'd14 << 6) | (24'd13 << 18); tbl[11].glat = 12'd5 << 3;
    tbl[12].e_err = 4'b1010;
    // Alloc/dealloc race on entry 6, dealloc entry 0
    tbl[12].aen = 1; tbl[12].aidx = 6; tbl[12].p1 = 20; tbl[12].p2 = 21; tbl[12].r1 = 1;
    tbl[12].dealloc = 16'h0041;
    // Flush with tags in flight and four valid entries
    tbl[13].aen = 1; tbl[13].aidx = 1; tbl[13].p1 = 22; tbl[13].p2 = 23; tbl[13].r1 = 1; tbl[13].r2 = 1;
    tbl[13].gvld = 4'b0011; tbl[13].gprd = 24'd30 | (24'd31 << 6); tbl[13].glat = 12'd3 | (12'd4 << 3);
    tbl[13].e_p1 = 16'h0048; tbl[13].e_p2 = 16'h0008; tbl[13].e_er = 16'h0008;
    tbl[14].aen = 1; tbl[14].aidx = 2;
    tbl[14].e_p1 = 16'h004A; tbl[14].e_p2 = 16'h000A; tbl[14].e_er = 16'h000A;
    tbl[15].flush = 1;
    tbl[15].e_p1 = 16'h004E; tbl[15].e_p2 = 16'h000E; tbl[15].e_er = 16'h000E;

    model_reset();
    drive(zv);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) step(tbl[i], 1'b1, i);

    for (int i = 0; i < 600; i++) step(rand_vec(), 1'b0, 0);

    // Asynchronous reset between clock edges clears every output at once.
    #2;
    rst_n = 1'b0;
    drive(zv);
    #1;
    chk("async_rst_tag_bus_vld", 64'(tag_bus_vld), 64'd0);
    chk("async_rst_tag_bus", 64'(tag_bus), 64'd0);
    chk("async_rst_prs1_rdy", 64'(prs1_rdy), 64'd0);
    chk("async_rst_prs2_rdy", 64'(prs2_rdy), 64'd0);
    chk("async_rst_entry_rdy", 64'(entry_rdy), 64'd0);
    chk("async_rst_lat", 64'({lat_conflict, lat_err}), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) step(rand_vec(), 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
